// File: rtl/cpu_ctrl_pkg.sv
// Shared control-bundle layout, bubble value and forwarding-select encodings
// used by the ID/EX/MEM/WB control pipeline of the 5-stage ARM core.
package cpu_ctrl_pkg;

    // Field order is fixed: the decoder packs id_ctrl in exactly this layout.
    typedef struct packed {
        logic       RegWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       ALU_Src;
        logic       ALU_SH;
        logic       Imm;
        logic       shiftDirn;
        logic       ALU_on;
        logic       set_flags;
        logic       branchLink;
        logic       uncondBr;
        logic       branch;
        logic       branchReg;
        logic [1:0] fwdEn;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int ZERO_REG = 31;

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage forwarding compare for both ALU operands against
// the MEM and WB destinations; MEM wins over WB, XZR never forwards.
module fwd_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = cpu_ctrl_pkg::ZERO_REG
) (
    input  logic [1:0]       ex_fwd_en,
    input  logic [REG_W-1:0] ex_rn,
    input  logic [REG_W-1:0] ex_rm,
    input  logic             mem_reg_write,
    input  logic             mem_to_reg,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    logic [REG_W-1:0] src [0:1];
    logic             en  [0:1];
    logic [1:0]       sel [0:1];

    assign src[0] = ex_rn;
    assign src[1] = ex_rm;
    // Operand A is enabled by fwdEn[1], operand B by fwdEn[0].
    assign en[0]  = ex_fwd_en[1];
    assign en[1]  = ex_fwd_en[0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic mem_hit;
            logic wb_hit;
            // A load in MEM has no data yet; its value is picked up from WB.
            assign mem_hit = mem_reg_write && !mem_to_reg
                          && (mem_rd == src[gi]) && (mem_rd != ZERO_IDX);
            assign wb_hit  = wb_reg_write
                          && (wb_rd == src[gi]) && (wb_rd != ZERO_IDX);
            assign sel[gi] = !en[gi] ? FWD_RF  :
                             mem_hit ? FWD_MEM :
                             wb_hit  ? FWD_WB  : FWD_RF;
        end
    endgenerate

    assign fwd_a = sel[0];
    assign fwd_b = sel[1];

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline registers ID->EX->MEM->WB with load-use stall, taken-branch
// squash, operand forwarding selects and saturating stall/flush counters.
module ctrl_pipeline
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = cpu_ctrl_pkg::ZERO_REG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  ctrl_t            id_ctrl,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             ex_taken,
    output logic             stall,
    output logic             if_flush,
    output ctrl_t            ex_ctrl,
    output ctrl_t            mem_ctrl,
    output ctrl_t            wb_ctrl,
    output logic [REG_W-1:0] ex_rd,
    output logic [REG_W-1:0] mem_rd,
    output logic [REG_W-1:0] wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    ctrl_t            ex_ctrl_q,  ex_ctrl_d;
    ctrl_t            mem_ctrl_q, mem_ctrl_d;
    ctrl_t            wb_ctrl_q,  wb_ctrl_d;
    logic [REG_W-1:0] ex_rd_q,  ex_rd_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic [REG_W-1:0] wb_rd_q,  wb_rd_d;
    logic [REG_W-1:0] ex_rn_q,  ex_rn_d;
    logic [REG_W-1:0] ex_rm_q,  ex_rm_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hit_rn;
    logic hit_rm;

    // STUR reads rm as store data even though it does not forward B.
    assign hit_rn = (ex_rd_q == id_rn) && id_ctrl.fwdEn[1];
    assign hit_rm = (ex_rd_q == id_rm) && (id_ctrl.fwdEn[0] || id_ctrl.memWrite);

    assign stall    = ex_ctrl_q.memRead && (ex_rd_q != ZERO_IDX)
                   && (hit_rn || hit_rm) && id_valid && !ex_taken;
    assign if_flush = ex_taken;

    always_comb begin
        mem_ctrl_d  = ex_ctrl_q;
        mem_rd_d    = ex_rd_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_rd_d     = mem_rd_q;
        ex_ctrl_d   = id_ctrl;
        ex_rd_d     = id_rd;
        ex_rn_d     = id_rn;
        ex_rm_d     = id_rm;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // Invalid ID, squash and stall all insert the same bubble into EX.
        if (!id_valid || ex_taken || stall) begin
            ex_ctrl_d = CTRL_BUBBLE;
            ex_rd_d   = ZERO_IDX;
            ex_rn_d   = '0;
            ex_rm_d   = '0;
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_ctrl_q   <= CTRL_BUBBLE;
            mem_ctrl_q  <= CTRL_BUBBLE;
            wb_ctrl_q   <= CTRL_BUBBLE;
            ex_rd_q     <= '0;
            mem_rd_q    <= '0;
            wb_rd_q     <= '0;
            ex_rn_q     <= '0;
            ex_rm_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            mem_ctrl_q  <= mem_ctrl_d;
            wb_ctrl_q   <= wb_ctrl_d;
            ex_rd_q     <= ex_rd_d;
            mem_rd_q    <= mem_rd_d;
            wb_rd_q     <= wb_rd_d;
            ex_rn_q     <= ex_rn_d;
            ex_rm_q     <= ex_rm_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fwd_unit #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_fwd (
        .ex_fwd_en     (ex_ctrl_q.fwdEn),
        .ex_rn         (ex_rn_q),
        .ex_rm         (ex_rm_q),
        .mem_reg_write (mem_ctrl_q.RegWrite),
        .mem_to_reg    (mem_ctrl_q.memToReg),
        .mem_rd        (mem_rd_q),
        .wb_reg_write  (wb_ctrl_q.RegWrite),
        .wb_rd         (wb_rd_q),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    assign ex_ctrl   = ex_ctrl_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign ex_rd     = ex_rd_q;
    assign mem_rd    = mem_rd_q;
    assign wb_rd     = wb_rd_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
